// File: rtl/de0_nano_dbg_panel.sv
// Board debug front-end: key debounce, CPU clock-enable,
// register address latch and windowed LED display.
module de0_nano_dbg_panel #(
  parameter int NUM_KEYS   = 2,
  parameter int DEB_CYCLES = 250000,
  parameter int DIV_LOG2   = 23,
  parameter int DATA_W     = 32,
  parameter int LED_W      = 8,
  parameter int SW_W       = 4
) (
  input  logic                clkIn,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [SW_W-1:0]     sw,
  input  logic                runMode,
  input  logic [DATA_W-1:0]   regData,
  output logic [4:0]          regAddr,
  output logic                cpuEn,
  output logic [NUM_KEYS-1:0] keyPulse,
  output logic [LED_W-1:0]    led
);

  localparam int W     = LED_W - 1;
  localparam int NWIN  = (DATA_W + W - 1) / W;
  localparam int WIN_W = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam int PAD_W = NWIN * W;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(NWIN - 1);

  logic [NUM_KEYS-1:0]            k_s0;
  logic [NUM_KEYS-1:0]            k_s1;
  logic [NUM_KEYS-1:0]            k_stb;
  logic [NUM_KEYS-1:0][CNT_W-1:0] k_cnt;

  logic [1:0]          run_s;
  logic [DIV_LOG2-1:0] div_q;
  logic [DIV_LOG2-1:0] div_nx;
  logic                en_nx;
  logic                hb;

  logic [SW_W-1:0]  sw_s;
  logic             sw_chg;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_nx;
  logic [PAD_W-1:0] pad;
  logic [W-1:0]     disp_nx;
  logic [W-1:0]     disp_q;

  // Synchronise keys, accept a level once stable, pulse on press
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      k_s0     <= '1;
      k_s1     <= '1;
      k_stb    <= '1;
      k_cnt    <= '0;
      keyPulse <= '0;
    end else begin
      k_s0 <= key_n;
      k_s1 <= k_s0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        keyPulse[i] <= 1'b0;
        if (k_s1[i] == k_stb[i]) begin
          k_cnt[i] <= '0;
        end else if (k_cnt[i] == DEB_LAST) begin
          k_cnt[i]    <= '0;
          k_stb[i]    <= k_s1[i];
          keyPulse[i] <= ~k_s1[i];
        end else begin
          k_cnt[i] <= k_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Divider runs only in free-run mode; enable fires while it is all-ones
  always_comb begin
    div_nx = '0;
    en_nx  = keyPulse[0];
    if (run_s[1]) begin
      div_nx = div_q + DIV_LOG2'(1);
      en_nx  = &div_nx;
    end
  end

  // Run-mode sync, divider, enable and heartbeat registers
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      run_s <= '0;
      div_q <= '0;
      cpuEn <= 1'b0;
      hb    <= 1'b0;
    end else begin
      run_s <= {run_s[0], runMode};
      div_q <= div_nx;
      cpuEn <= en_nx;
      hb    <= hb ^ en_nx;
    end
  end

  assign sw_chg = (sw_s != regAddr[SW_W-1:0]);
  assign pad    = PAD_W'(regData);

  // Window select: a new address returns to window 0 before any advance
  always_comb begin
    win_nx = win_q;
    if (sw_chg) begin
      win_nx = '0;
    end else if (keyPulse[1]) begin
      win_nx = (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);
    end
    disp_nx = pad[win_q*W +: W];
  end

  // Switch synchroniser, window index and display registers
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      sw_s    <= '0;
      regAddr <= '0;
      win_q   <= '0;
      disp_q  <= '0;
    end else begin
      sw_s    <= sw;
      regAddr <= 5'(sw_s);
      win_q   <= win_nx;
      disp_q  <= disp_nx;
    end
  end

  assign led = {disp_q, hb};

endmodule

// File: tb/tb_de0_nano_dbg_panel.sv
// Bench for de0_nano_dbg_panel: pulse scoreboard plus
// directed display/address checks.
module tb_de0_nano_dbg_panel;

  localparam int DEB = 4;

  typedef struct {
    int         cyc;
    logic [1:0] kp;
    logic       en;
  } ev_t;

  logic       clkIn = 1'b0;
  logic       rst_n;
  logic [1:0] key_n;
  logic [3:0] sw;
  logic       runMode;
  logic [31:0] regData;
  logic [4:0] regAddr;
  logic       cpuEn;
  logic [1:0] keyPulse;
  logic [7:0] led;

  ev_t  q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic exp_hb = 1'b0;

  de0_nano_dbg_panel #(
    .NUM_KEYS(2),
    .DEB_CYCLES(DEB),
    .DIV_LOG2(3),
    .DATA_W(32),
    .LED_W(8),
    .SW_W(4)
  ) dut (
    .clkIn(clkIn),
    .rst_n(rst_n),
    .key_n(key_n),
    .sw(sw),
    .runMode(runMode),
    .regData(regData),
    .regAddr(regAddr),
    .cpuEn(cpuEn),
    .keyPulse(keyPulse),
    .led(led)
  );

  always #5 clkIn = ~clkIn;

  always @(posedge clkIn) cyc++;

  // Monitor: every enable/pulse must match the next expected event
  always @(negedge clkIn) begin
    ev_t e;
    if (!rst_n) begin
      exp_hb = 1'b0;
    end else if (cpuEn || keyPulse != 2'b00) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d kp=%b en=%b", cyc, keyPulse, cpuEn);
        if (cpuEn) exp_hb = ~exp_hb;
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.kp != keyPulse || e.en != cpuEn) begin
          errors++;
          $display("FAIL event got cyc=%0d kp=%b en=%b want cyc=%0d kp=%b en=%b",
                   cyc, keyPulse, cpuEn, e.cyc, e.kp, e.en);
        end
        if (cpuEn) begin
          exp_hb = ~exp_hb;
          checks++;
          if (led[0] !== exp_hb) begin
            errors++;
            $display("FAIL heartbeat got %b want %b", led[0], exp_hb);
          end
        end
      end
    end else if (q.size() != 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event at cyc=%0d kp=%b en=%b", e.cyc, e.kp, e.en);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic press(input int k);
    int c;
    key_n[k] = 1'b0;
    c = cyc;
    q.push_back('{c + 2 + DEB, 2'(1 << k), 1'b0});
    if (k == 0 && !runMode) q.push_back('{c + 3 + DEB, 2'b00, 1'b1});
    repeat (8) @(negedge clkIn);
    key_n[k] = 1'b1;
    repeat (8) @(negedge clkIn);
  endtask

  logic [6:0] win_exp [5];

  initial begin
    int c;
    int r;
    win_exp[0] = 7'h7D;
    win_exp[1] = 7'h36;
    win_exp[2] = 7'h75;
    win_exp[3] = 7'h0D;
    win_exp[4] = 7'h6F;

    rst_n   = 1'b0;
    key_n   = 2'b11;
    sw      = 4'd3;
    runMode = 1'b0;
    regData = 32'h0;
    repeat (3) @(negedge clkIn);
    chk("rst_cpuEn", 32'(cpuEn), 32'h0);
    chk("rst_keyPulse", 32'(keyPulse), 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_regAddr", 32'(regAddr), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clkIn);
    chk("regAddr_sw3", 32'(regAddr), 32'h3);

    // 1: bouncy press, then bouncy release
    for (int i = 0; i < 6; i++) begin
      key_n[0] = (i % 2 == 1);
      repeat (2) @(negedge clkIn);
    end
    key_n[0] = 1'b0;
    c = cyc;
    q.push_back('{c + 6, 2'b01, 1'b0});
    q.push_back('{c + 7, 2'b00, 1'b1});
    repeat (12) @(negedge clkIn);
    key_n[0] = 1'b1;
    @(negedge clkIn);
    key_n[0] = 1'b0;
    @(negedge clkIn);
    key_n[0] = 1'b1;
    repeat (12) @(negedge clkIn);

    // 2: free run, one enable every 8 cycles
    runMode = 1'b1;
    r = cyc;
    for (int j = 0; j < 8; j++) q.push_back('{r + 9 + 8 * j, 2'b00, 1'b1});
    repeat (64) @(negedge clkIn);
    runMode = 1'b0;
    repeat (10) @(negedge clkIn);

    // 3: single step on three clean presses
    for (int j = 0; j < 3; j++) press(0);

    // 4: window scrolling
    regData = 32'hDEADBEEF;
    repeat (3) @(negedge clkIn);
    chk("win0", 32'(led[7:1]), 32'h6F);
    for (int j = 0; j < 5; j++) begin
      press(1);
      chk($sformatf("win_step%0d", j + 1), 32'(led[7:1]), 32'(win_exp[j]));
    end

    // 5: switch change coinciding with an advance pulse
    press(1);
    press(1);
    chk("win2", 32'(led[7:1]), 32'h36);
    key_n[1] = 1'b0;
    c = cyc;
    q.push_back('{c + 6, 2'b10, 1'b0});
    repeat (5) @(negedge clkIn);
    sw = 4'd5;
    @(negedge clkIn);
    chk("regAddr_lat1", 32'(regAddr), 32'h3);
    @(negedge clkIn);
    chk("regAddr_lat2", 32'(regAddr), 32'h5);
    repeat (4) @(negedge clkIn);
    chk("sw_wins", 32'(led[7:1]), 32'h6F);
    key_n[1] = 1'b1;
    repeat (8) @(negedge clkIn);

    // 6: asynchronous reset mid-count
    runMode = 1'b1;
    r = cyc;
    q.push_back('{r + 9, 2'b00, 1'b1});
    repeat (10) @(negedge clkIn);
    key_n[0] = 1'b0;
    repeat (4) @(posedge clkIn);
    #2;
    chk("pre_rst_regAddr", 32'(regAddr), 32'h5);
    rst_n = 1'b0;
    #1;
    chk("async_cpuEn", 32'(cpuEn), 32'h0);
    chk("async_keyPulse", 32'(keyPulse), 32'h0);
    chk("async_led", 32'(led), 32'h0);
    chk("async_regAddr", 32'(regAddr), 32'h0);
    key_n   = 2'b11;
    runMode = 1'b0;
    @(negedge clkIn);
    rst_n = 1'b1;
    repeat (20) @(negedge clkIn);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
